pwl_activation: RTL
===================

Name: pwl_activation

Overview:
- Pipelined, parametrised piecewise-linear activation unit for the fixed-point GRU/LSTM datapath.
- Evaluates sigmoid, and optionally tanh, from a runtime-writable slope/intercept table with NSEG uniform segments.
- Sits between the gate MAC accumulators and the state-update logic.
- Adds valid/ready flow control, saturation and a config port on top of the fixed 3-segment sigmoid.

Parameters:
- W, 16, data width, signed two's complement in and out.
- FRAC, 14, fractional bits; ONE = 1<<FRAC = 0x4000.
- NSEG, 4, number of table segments, power of 2.
- SEG_SHIFT, 13, log2 of segment width in input LSBs (default width 0.5).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit can accept a sample.
- in_data  in  W  signed fixed-point x.
- in_mode  in  1  0 = sigmoid, 1 = tanh (see Optional Feature).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  signed fixed-point result.
- cfg_we  in  1  table write strobe.
- cfg_sel  in  1  0 = slope table, 1 = intercept table.
- cfg_addr  in  log2(NSEG)  table entry.
- cfg_data  in  W  unsigned entry value.

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, all stage valids=0, in-flight samples discarded.
- Reset table contents: slope/intercept pairs m0=0x1000/b0=0x2000, m1=0x0DE6/b1=0x27D6, m2=0x0995/b2=0x2EC9, m3=0x0700/b3=0x3453. Entries k>=4 reset to m=0, b=ONE.
- Pipeline: 3 register stages S1..S3, each holding a valid bit. Global advance adv = ~out_valid | out_ready. in_ready = adv (combinational).
- Transfer rules: accept when in_valid & in_ready. All stages shift only when adv; otherwise every stage holds. No bubble squeezing.
- Latency: 3 cycles from accept to out_valid with no stall; throughput 1 sample/cycle.
- S1 (magnitude and table lookup):
  - sgn = x[W-1].
  - a = |x|, saturating: x = -2^(W-1) gives 2^(W-1)-1.
  - Tanh mode: a = 2*a, computed in W+1 bits.
  - k = a >> SEG_SHIFT; delta = a - (k<<SEG_SHIFT).
  - sat = (k >= NSEG).
  - Register m[k], b[k], delta, sgn, mode, sat.
- S2 (multiply): p = (m * delta) >> FRAC, unsigned, truncating.
- S3 (combine and output):
  - y = sat ? ONE : min(b + p, ONE).
  - Sigmoid: out = sgn ? ONE - y : y.
  - Tanh: s = sgn ? ONE - y : y; out = 2*s - ONE.
  - out_data is driven directly from the S3 register.
- Output ranges: sigmoid in [0, ONE]; tanh in [-ONE, ONE].
- Config writes:
  - A write with cfg_we=1 updates the entry at the clock edge.
  - Samples whose S1 load occurs in the same cycle read the old value; later samples read the new value.
  - Writes are independent of stall state.
  - cfg_addr >= NSEG is ignored.
- Simultaneous accept and output with out_ready=1: both occur, no loss.
- A stall with out_ready=0 holds out_data/out_valid stable until accepted.

Optional Feature:
- Macro PWL_TANH_MODE_EN.
- Defined: in_mode is honoured per sample and carried down the pipeline; tanh computed as 2*sig(2x)-1.
- Undefined: in_mode is ignored, doubling and tanh logic are removed, and every sample produces sigmoid.

Test Plan:
- Reset defaults, sigmoid:
  - x=0x0000 -> 0x2000.
  - x=0x1000 -> 0x2400.
  - x=0x2000 -> 0x27D6.
  - x=-0x2000 (0xE000) -> 0x182A.
  - Each result appears exactly 3 cycles after accept.
- Extremes:
  - x=0x7FFF -> 0x37D2.
  - x=0x8000 -> 0x082E (saturated abs; 0x4000-0x37D2).
  - Back-to-back stream of 8 samples yields 8 consecutive out_valid cycles, results in input order.
- Tanh (macro defined):
  - x=0x1000 -> 0x0FAC.
  - x=0xF000 -> 0xF054.
  - x=0x7000 (doubled k=7 >= NSEG) -> 0x4000.
  - With macro undefined, the same in_mode=1 input x=0x1000 -> 0x2400.
- Backpressure:
  - Feed 4 samples, hold out_ready=0 for 5 cycles.
  - in_ready drops once out_valid=1; out_data stays stable.
  - After release, all 4 results emerge in order with no drop or duplicate.
- Config:
  - Write slope[0]=0 and intercept[0]=0x3000; next x=0x1000 -> 0x3000.
  - A sample accepted in the same cycle as the write still gives 0x2400.
  - A write to cfg_addr out of range with NSEG=4 is impossible by width; with NSEG=8, writing entry 5 changes only k=5 results.
- Reset mid-stream:
  - Assert rst_n low with 3 samples in flight; out_valid goes 0 immediately.
  - No stale result after release.
  - Table returns to defaults: x=0x2000 -> 0x27D6.

Source files
------------

// File: rtl/pwl_activation.sv
// Three-stage piecewise-linear sigmoid (optionally tanh) with a runtime-writable slope/intercept table.
// Define PWL_TANH_MODE_EN to honour in_mode per sample; otherwise every sample produces sigmoid.
module pwl_activation #(
   parameter int W         = 16,
   parameter int FRAC      = 14,
   parameter int NSEG      = 4,
   parameter int SEG_SHIFT = 13
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            in_data,
   input  logic                    in_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [W-1:0]            out_data,
   input  logic                    cfg_we,
   input  logic                    cfg_sel,
   input  logic [$clog2(NSEG)-1:0] cfg_addr,
   input  logic [W-1:0]            cfg_data
);

   localparam int AW = $clog2(NSEG);
   localparam int KW = W + 1 - SEG_SHIFT;
   localparam int PW = W + SEG_SHIFT - FRAC;
   localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0] slope_tab [NSEG];
   logic [W-1:0] icpt_tab  [NSEG];

   function automatic logic [W-1:0] reset_slope(input int k);
      case (k)
         0:       return W'(16'h1000);
         1:       return W'(16'h0DE6);
         2:       return W'(16'h0995);
         3:       return W'(16'h0700);
         default: return '0;
      endcase
   endfunction

   function automatic logic [W-1:0] reset_icpt(input int k);
      case (k)
         0:       return W'(16'h2000);
         1:       return W'(16'h27D6);
         2:       return W'(16'h2EC9);
         3:       return W'(16'h3453);
         default: return ONE;
      endcase
   endfunction

   logic adv;
   logic cfg_in_range;

   assign adv          = ~out_valid | out_ready;
   assign in_ready     = adv;
   assign cfg_in_range = ({1'b0, cfg_addr} < (AW+1)'(NSEG));

   // Table writes land at the edge, so a sample loading S1 on the same edge still sees the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSEG; i++) begin
            slope_tab[i] <= reset_slope(i);
            icpt_tab[i]  <= reset_icpt(i);
         end
      end else if (cfg_we && cfg_in_range) begin
         if (cfg_sel) icpt_tab[cfg_addr]  <= cfg_data;
         else         slope_tab[cfg_addr] <= cfg_data;
      end
   end

   logic                 x_sgn;
   logic [W-1:0]         x_abs;
   logic [W:0]           a_ext;
   logic [KW-1:0]        seg_k;
   logic [AW-1:0]        seg_idx;
   logic [SEG_SHIFT-1:0] seg_delta;
   logic                 seg_sat;

   assign x_sgn = in_data[W-1];
   assign x_abs = (in_data == MIN_NEG) ? MAX_POS : (x_sgn ? -in_data : in_data);

`ifdef PWL_TANH_MODE_EN
   assign a_ext = in_mode ? {x_abs, 1'b0} : {1'b0, x_abs};
`else
   logic unused_mode;
   assign unused_mode = in_mode;
   assign a_ext       = {1'b0, x_abs};
`endif

   assign seg_k     = a_ext[W:SEG_SHIFT];
   assign seg_idx   = seg_k[AW-1:0];
   assign seg_delta = a_ext[SEG_SHIFT-1:0];
   assign seg_sat   = ({{(32-KW){1'b0}}, seg_k} >= 32'(NSEG));

   logic                 s1_valid, s1_sgn, s1_sat;
   logic [W-1:0]         s1_m, s1_b;
   logic [SEG_SHIFT-1:0] s1_delta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sgn   <= 1'b0;
         s1_sat   <= 1'b0;
         s1_m     <= '0;
         s1_b     <= '0;
         s1_delta <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_sgn   <= x_sgn;
         s1_sat   <= seg_sat;
         s1_m     <= slope_tab[seg_idx];
         s1_b     <= icpt_tab[seg_idx];
         s1_delta <= seg_delta;
      end
   end

   logic [W+SEG_SHIFT-1:0] prod;
   logic [FRAC-1:0]        unused_prod_lo;
   logic                   s2_valid, s2_sgn, s2_sat;
   logic [W-1:0]           s2_b;
   logic [PW-1:0]          s2_p;

   assign prod           = {{SEG_SHIFT{1'b0}}, s1_m} * {{W{1'b0}}, s1_delta};
   assign unused_prod_lo = prod[FRAC-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_sgn   <= 1'b0;
         s2_sat   <= 1'b0;
         s2_b     <= '0;
         s2_p     <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_sgn   <= s1_sgn;
         s2_sat   <= s1_sat;
         s2_b     <= s1_b;
         s2_p     <= prod[W+SEG_SHIFT-1:FRAC];
      end
   end

   logic [W:0]   seg_sum;
   logic [W-1:0] y_pos;
   logic [W-1:0] sig_val;
   logic [W-1:0] result;

   assign seg_sum = {1'b0, s2_b} + {{(W+1-PW){1'b0}}, s2_p};
   assign y_pos   = (s2_sat || (seg_sum > {1'b0, ONE})) ? ONE : seg_sum[W-1:0];
   assign sig_val = s2_sgn ? (ONE - y_pos) : y_pos;

`ifdef PWL_TANH_MODE_EN
   logic s1_mode, s2_mode;
   logic [W-1:0] tanh_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_mode <= 1'b0;
         s2_mode <= 1'b0;
      end else if (adv) begin
         s1_mode <= in_mode;
         s2_mode <= s1_mode;
      end
   end

   // sig_val never exceeds ONE, so doubling in W bits and subtracting ONE wraps to the right signed value.
   assign tanh_val = {sig_val[W-2:0], 1'b0} - ONE;
   assign result   = s2_mode ? tanh_val : sig_val;
`else
   assign result = sig_val;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         out_data  <= result;
      end
   end

endmodule
